// File: rtl/hazard_sched.sv
// hazard_sched: pipeline sequencing controller for the 5-stage MIPS core.
// Detects load-use hazards, squashes wrong-path fetches after a taken branch,
// freezes the back end while data memory is busy, and halts on an undefined
// instruction or a data-memory timeout.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   IfId_Inst      instruction in decode (rs/rt/opcode used for load-use)
//   UndefInst      undefined-opcode flag from decode
//   IdEx_MemR/Rt   load in EX and its destination register
//   Branch_taken   taken branch/jump resolved in EX
//   ExMem_MemReq   MEM-stage data access, DMem_ready completes it
//   Pipe_stall     bubble request to the decode control unit
//   PC_write, IfId_write, IfId_flush, IdEx_flush, Freeze   pipe enables
//   Halt, ExcCode  sticky halt and its cause (01 undef, 10 mem timeout)
//   StallCnt       saturating count of cycles with PC_write=0
module hazard_sched #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IfId_Inst,
  input  logic             UndefInst,
  input  logic             IdEx_MemR,
  input  logic [4:0]       IdEx_Rt,
  input  logic             Branch_taken,
  input  logic             ExMem_MemReq,
  input  logic             DMem_ready,
  output logic             Pipe_stall,
  output logic             PC_write,
  output logic             IfId_write,
  output logic             IfId_flush,
  output logic             IdEx_flush,
  output logic             Freeze,
  output logic             Halt,
  output logic [1:0]       ExcCode,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT, HALT} state_t;

  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMO       = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt, ret_q, ret_nxt, act;
  logic [2:0] fcnt_q, fcnt_nxt;
  logic [7:0] tcnt_q, tcnt_nxt, tcnt_inc;
  logic [1:0] exc_nxt;
  logic       memwait, load_use, rt_src, do_run;
  logic [5:0] opcode;
  logic [15:0] unused_bits;

  assign unused_bits = IfId_Inst[15:0];
  assign opcode   = IfId_Inst[31:26];
  // rt is a source only for R-type, beq, bne and sw
  assign rt_src   = (opcode == 6'h00) || (opcode == 6'h04) ||
                    (opcode == 6'h05) || (opcode == 6'h2b);
  assign load_use = IdEx_MemR && (IdEx_Rt != 5'd0) &&
                    ((IdEx_Rt == IfId_Inst[25:21]) ||
                     ((IdEx_Rt == IfId_Inst[20:16]) && rt_src));
  assign memwait  = ExMem_MemReq && !DMem_ready;
  assign tcnt_inc = tcnt_q + 8'd1;

  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_q;
    fcnt_nxt   = fcnt_q;
    tcnt_nxt   = tcnt_q;
    exc_nxt    = ExcCode;
    act        = state;
    do_run     = 1'b0;
    Pipe_stall = 1'b0;
    PC_write   = 1'b1;
    IfId_write = 1'b1;
    IfId_flush = 1'b0;
    IdEx_flush = 1'b0;
    Freeze     = 1'b0;
    Halt       = 1'b0;
    if (rst) begin
      state_nxt  = RUN;
      ret_nxt    = RUN;
      fcnt_nxt   = '0;
      tcnt_nxt   = '0;
      exc_nxt    = 2'b00;
      Pipe_stall = 1'b1;
      PC_write   = 1'b0;
      IfId_write = 1'b0;
      IfId_flush = 1'b1;
      IdEx_flush = 1'b1;
    end else begin
      case (state)
        HALT: begin
          Halt       = 1'b1;
          Freeze     = 1'b1;
          Pipe_stall = 1'b1;
          PC_write   = 1'b0;
          IfId_write = 1'b0;
        end
        MEMWAIT: begin
          if (!DMem_ready) begin
            Freeze     = 1'b1;
            PC_write   = 1'b0;
            IfId_write = 1'b0;
            tcnt_nxt   = tcnt_inc;
            if (tcnt_inc == TMO) begin
              state_nxt = HALT;
              exc_nxt   = 2'b10;
            end
          end else begin
            // ready cycle: pipe moves again, behave as the saved state would
            tcnt_nxt = '0;
            act      = ret_q;
            do_run   = 1'b1;
          end
        end
        default: begin
          if (memwait) begin
            Freeze     = 1'b1;
            PC_write   = 1'b0;
            IfId_write = 1'b0;
            ret_nxt    = state;
            tcnt_nxt   = tcnt_inc;
            if (tcnt_inc == TMO) begin
              state_nxt = HALT;
              exc_nxt   = 2'b10;
            end else begin
              state_nxt = MEMWAIT;
            end
          end else begin
            do_run = 1'b1;
          end
        end
      endcase

      if (do_run) begin
        state_nxt = RUN;
        if (Branch_taken) begin
          IfId_flush = 1'b1;
          IdEx_flush = 1'b1;
          if (FL_RELOAD != 3'd0) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FL_RELOAD;
          end
        end else if (act == FLUSH) begin
          // wrong-path slot: undef and load-use are meaningless here
          IfId_flush = 1'b1;
          if (fcnt_q > 3'd1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = fcnt_q - 3'd1;
          end else begin
            fcnt_nxt  = '0;
          end
        end else if (UndefInst) begin
          Pipe_stall = 1'b1;
          PC_write   = 1'b0;
          IfId_write = 1'b0;
          state_nxt  = HALT;
          exc_nxt    = 2'b01;
        end else if (load_use) begin
          Pipe_stall = 1'b1;
          PC_write   = 1'b0;
          IfId_write = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      ret_q    <= RUN;
      fcnt_q   <= '0;
      tcnt_q   <= '0;
      ExcCode  <= 2'b00;
      StallCnt <= '0;
    end else begin
      state   <= state_nxt;
      ret_q   <= ret_nxt;
      fcnt_q  <= fcnt_nxt;
      tcnt_q  <= tcnt_nxt;
      ExcCode <= exc_nxt;
      if (state != HALT && !PC_write && StallCnt != '1)
        StallCnt <= StallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched. Main instance: FLUSH_CYCLES=3,
// MEM_TIMEOUT=15, CNT_W=16. A second instance with CNT_W=4 shares the
// inputs and is used for the counter saturation check.
module tb_hazard_sched;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] IfId_Inst;
  logic UndefInst, IdEx_MemR, Branch_taken, ExMem_MemReq, DMem_ready;
  logic [4:0] IdEx_Rt;
  logic Pipe_stall, PC_write, IfId_write, IfId_flush, IdEx_flush, Freeze, Halt;
  logic [1:0] ExcCode;
  logic [15:0] StallCnt;
  logic d1_stall, d1_pcw, d1_iw, d1_iff, d1_ixf, d1_frz, d1_halt;
  logic [1:0] d1_exc;
  logic [3:0] d1_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_sched #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .IfId_Inst(IfId_Inst), .UndefInst(UndefInst),
    .IdEx_MemR(IdEx_MemR), .IdEx_Rt(IdEx_Rt), .Branch_taken(Branch_taken),
    .ExMem_MemReq(ExMem_MemReq), .DMem_ready(DMem_ready),
    .Pipe_stall(Pipe_stall), .PC_write(PC_write), .IfId_write(IfId_write),
    .IfId_flush(IfId_flush), .IdEx_flush(IdEx_flush), .Freeze(Freeze),
    .Halt(Halt), .ExcCode(ExcCode), .StallCnt(StallCnt));

  hazard_sched #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .IfId_Inst(IfId_Inst), .UndefInst(UndefInst),
    .IdEx_MemR(IdEx_MemR), .IdEx_Rt(IdEx_Rt), .Branch_taken(Branch_taken),
    .ExMem_MemReq(ExMem_MemReq), .DMem_ready(DMem_ready),
    .Pipe_stall(d1_stall), .PC_write(d1_pcw), .IfId_write(d1_iw),
    .IfId_flush(d1_iff), .IdEx_flush(d1_ixf), .Freeze(d1_frz),
    .Halt(d1_halt), .ExcCode(d1_exc), .StallCnt(d1_cnt));

  // {Pipe_stall, PC_write, IfId_write, IfId_flush, IdEx_flush, Freeze, Halt}
  localparam logic [6:0] EN_RST   = 7'b1001100;
  localparam logic [6:0] EN_IDLE  = 7'b0110000;
  localparam logic [6:0] EN_STALL = 7'b1000000;
  localparam logic [6:0] EN_BR    = 7'b0111100;
  localparam logic [6:0] EN_FL    = 7'b0111000;
  localparam logic [6:0] EN_FRZ   = 7'b0000010;
  localparam logic [6:0] EN_HALT  = 7'b1000011;

  localparam logic [31:0] ADD_3_2_4 = {6'h00, 5'd2, 5'd4, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] ADD_3_0_4 = {6'h00, 5'd0, 5'd4, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] LW_4_1    = {6'h23, 5'd1, 5'd4, 16'h0000};
  localparam logic [31:0] BEQ_1_4   = {6'h04, 5'd1, 5'd4, 16'h0003};

  logic [6:0] en;
  assign en = {Pipe_stall, PC_write, IfId_write, IfId_flush, IdEx_flush, Freeze, Halt};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    IfId_Inst = 32'h0; UndefInst = 0; IdEx_MemR = 0; IdEx_Rt = 0;
    Branch_taken = 0; ExMem_MemReq = 0; DMem_ready = 0;
  endtask

  // inputs are applied at negedge; #1 lets combinational outputs settle
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle(); step(); step(); rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    step(); step();
    #1 chk("rst_en", 32'(en), 32'(EN_RST));
    chk("rst_exc", 32'(ExcCode), 0);
    chk("rst_cnt", 32'(StallCnt), 0);
    step(); rst = 0;
    #1 chk("idle_en", 32'(en), 32'(EN_IDLE));

    // load-use on rs
    step(); IdEx_MemR = 1; IdEx_Rt = 5'd2; IfId_Inst = ADD_3_2_4;
    #1 chk("lu_rs_en", 32'(en), 32'(EN_STALL));
    step(); idle();
    #1 chk("lu_after_en", 32'(en), 32'(EN_IDLE));
    chk("lu_cnt", 32'(StallCnt), 1);
    // Rt=0 never stalls
    step(); IdEx_MemR = 1; IdEx_Rt = 5'd0; IfId_Inst = ADD_3_0_4;
    #1 chk("lu_r0_en", 32'(en), 32'(EN_IDLE));
    // rt of lw is a destination, no stall
    step(); IdEx_MemR = 1; IdEx_Rt = 5'd4; IfId_Inst = LW_4_1;
    #1 chk("lu_lw_rt_en", 32'(en), 32'(EN_IDLE));
    // rt of beq is a source, stall
    step(); IfId_Inst = BEQ_1_4;
    #1 chk("lu_beq_rt_en", 32'(en), 32'(EN_STALL));
    step(); idle();
    #1 chk("lu_cnt2", 32'(StallCnt), 2);

    // taken branch, 3 flush slots, undef in slot 2 ignored
    step(); Branch_taken = 1;
    #1 chk("br_c1_en", 32'(en), 32'(EN_BR));
    step(); Branch_taken = 0; UndefInst = 1;
    #1 chk("br_c2_en", 32'(en), 32'(EN_FL));
    step(); UndefInst = 0;
    #1 chk("br_c3_en", 32'(en), 32'(EN_FL));
    step();
    #1 chk("br_done_en", 32'(en), 32'(EN_IDLE));
    chk("br_exc", 32'(ExcCode), 0);
    chk("br_cnt", 32'(StallCnt), 2);

    // memory wait: 4 not-ready cycles then ready
    for (int i = 0; i < 4; i++) begin
      step(); ExMem_MemReq = 1; DMem_ready = 0;
      #1 chk($sformatf("mw_frz%0d", i), 32'(en), 32'(EN_FRZ));
    end
    step(); DMem_ready = 1;
    #1 chk("mw_rdy_en", 32'(en), 32'(EN_IDLE));
    step(); idle();
    #1 chk("mw_cnt", 32'(StallCnt), 6);

    // memory wait inside a flush: the remaining flush slots resume
    step(); Branch_taken = 1;
    #1 chk("mwf_br_en", 32'(en), 32'(EN_BR));
    step(); Branch_taken = 0; ExMem_MemReq = 1; DMem_ready = 0;
    #1 chk("mwf_frz_en", 32'(en), 32'(EN_FRZ));
    step(); DMem_ready = 1;
    #1 chk("mwf_rdy_en", 32'(en), 32'(EN_FL));
    step(); idle();
    #1 chk("mwf_fl3_en", 32'(en), 32'(EN_FL));
    step();
    #1 chk("mwf_done_en", 32'(en), 32'(EN_IDLE));
    chk("mwf_cnt", 32'(StallCnt), 7);

    // memory timeout after 15 not-ready cycles
    for (int i = 0; i < 15; i++) begin
      step(); ExMem_MemReq = 1; DMem_ready = 0;
      #1 if (i == 0 || i == 14) chk($sformatf("to_frz%0d", i), 32'(en), 32'(EN_FRZ));
    end
    step();
    #1 chk("to_halt_en", 32'(en), 32'(EN_HALT));
    chk("to_exc", 32'(ExcCode), 2);
    step(); step(); DMem_ready = 1;
    #1 chk("to_sticky_en", 32'(en), 32'(EN_HALT));
    chk("to_cnt", 32'(StallCnt), 22);
    step(); rst = 1;
    #1 chk("to_rst_en", 32'(en), 32'(EN_RST));
    step(); rst = 0; idle();
    #1 chk("to_after_en", 32'(en), 32'(EN_IDLE));
    chk("to_after_halt", 32'(Halt), 0);
    chk("to_after_exc", 32'(ExcCode), 0);
    chk("to_after_cnt", 32'(StallCnt), 0);

    // undefined instruction halts next cycle
    step(); UndefInst = 1;
    #1 chk("ud_c1_en", 32'(en), 32'(EN_STALL));
    step(); UndefInst = 0;
    #1 chk("ud_halt_en", 32'(en), 32'(EN_HALT));
    chk("ud_exc", 32'(ExcCode), 1);
    chk("ud_cnt", 32'(StallCnt), 1);

    // undef together with branch: branch wins
    step(); do_reset();
    UndefInst = 1; Branch_taken = 1;
    #1 chk("udbr_c1_en", 32'(en), 32'(EN_BR));
    step(); Branch_taken = 0;
    #1 chk("udbr_c2_en", 32'(en), 32'(EN_FL));
    step();
    #1 chk("udbr_c3_en", 32'(en), 32'(EN_FL));
    step(); UndefInst = 0;
    #1 chk("udbr_done_en", 32'(en), 32'(EN_IDLE));
    chk("udbr_exc", 32'(ExcCode), 0);

    // reset mid-MEMWAIT aborts the wait
    step(); ExMem_MemReq = 1; DMem_ready = 0;
    step(); rst = 1;
    step(); rst = 0; idle();
    #1 chk("rmw_en", 32'(en), 32'(EN_IDLE));

    // counter saturation: 20 stall cycles
    step(); do_reset();
    IdEx_MemR = 1; IdEx_Rt = 5'd2; IfId_Inst = ADD_3_2_4;
    for (int i = 0; i < 20; i++) step();
    idle();
    #1 chk("sat_cnt16", 32'(StallCnt), 20);
    chk("sat_cnt4", 32'(d1_cnt), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
